// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: the packed entry carried from decode to execute.
package decode_queue_pkg;

    localparam int DQ_XLEN    = 32;
    localparam int DQ_NREGS   = 32;
    localparam int DQ_RADDR_W = $clog2(DQ_NREGS);

    typedef struct packed {
        logic [DQ_XLEN-1:0]    pc;
        logic [31:0]           instr;
        logic [DQ_RADDR_W-1:0] waddr;
        logic [DQ_RADDR_W-1:0] raddr1;
        logic [DQ_RADDR_W-1:0] raddr2;
        logic                  wren;
        logic                  rden1;
        logic                  rden2;
        logic                  long_op;
    } decode_queue_entry_type;

    localparam decode_queue_entry_type init_decode_queue_entry = '0;

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending bits for long-latency destinations; register 0 is never tracked.
module decode_scoreboard
    import decode_queue_pkg::*;
#(
    parameter int NREGS = DQ_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] src1_addr,
    input  logic [AW-1:0] src2_addr,
    input  logic [AW-1:0] dst_addr,
    output logic          src1_pend,
    output logic          src2_pend,
    output logic          dst_pend
);

    logic [NREGS-1:1] pend;
    logic [NREGS-1:1] pend_next;
    logic [NREGS-1:0] pend_vec;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        pend_next = pend;
        if (clr_en && clr_addr != '0)
            pend_next[clr_addr] = 1'b0;
        // Applied after the clear so a same-register collision leaves the bit set.
        if (set_en && set_addr != '0)
            pend_next[set_addr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset)
            pend <= '0;
        else
            pend <= pend_next;
    end

    assign pend_vec  = {pend, 1'b0};
    assign src1_pend = pend_vec[src1_addr];
    assign src2_pend = pend_vec[src2_addr];
    assign dst_pend  = pend_vec[dst_addr];

endmodule

// File: rtl/decode_queue.sv
// In-order instruction buffer between decode and execute with per-register long-op stalls.
// Optional same-cycle bypass into an empty queue: define DECODE_QUEUE_BYPASS_EN.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = DQ_XLEN,
    parameter int NREGS = DQ_NREGS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    input  logic [$clog2(NREGS)-1:0] in_waddr,
    input  logic [$clog2(NREGS)-1:0] in_raddr1,
    input  logic [$clog2(NREGS)-1:0] in_raddr2,
    input  logic                     in_wren,
    input  logic                     in_rden1,
    input  logic                     in_rden2,
    input  logic                     in_long,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(NREGS)-1:0] out_waddr,
    output logic [$clog2(NREGS)-1:0] out_raddr1,
    output logic [$clog2(NREGS)-1:0] out_raddr2,
    output logic                     out_wren,
    output logic                     out_rden1,
    output logic                     out_rden2,
    output logic                     out_long,
    input  logic                     wb_valid,
    input  logic [$clog2(NREGS)-1:0] wb_waddr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     hazard
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    decode_queue_entry_type mem [DEPTH];
    decode_queue_entry_type in_entry;
    decode_queue_entry_type head;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic empty, bypass, head_present, hazard_head;
    logic enq, deq, store, pop;
    logic src1_pend, src2_pend, dst_pend;

    always_comb begin
        in_entry         = init_decode_queue_entry;
        in_entry.pc      = in_pc;
        in_entry.instr   = in_instr;
        in_entry.waddr   = in_waddr;
        in_entry.raddr1  = in_raddr1;
        in_entry.raddr2  = in_raddr2;
        in_entry.wren    = in_wren;
        in_entry.rden1   = in_rden1;
        in_entry.rden2   = in_rden2;
        in_entry.long_op = in_long;
    end

    assign empty    = (count == '0);
    assign in_ready = (count < CNT_W'(DEPTH));

`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // Head reads as all-zero when nothing is queued, which keeps out_* clean after reset.
    always_comb begin
        head = init_decode_queue_entry;
        if (bypass)
            head = in_entry;
        else if (!empty)
            head = mem[rd_ptr];
    end

    decode_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (deq & head.long_op & head.wren),
        .set_addr  (head.waddr),
        .clr_en    (wb_valid),
        .clr_addr  (wb_waddr),
        .src1_addr (head.raddr1),
        .src2_addr (head.raddr2),
        .dst_addr  (head.waddr),
        .src1_pend (src1_pend),
        .src2_pend (src2_pend),
        .dst_pend  (dst_pend)
    );

    assign hazard_head  = (head.rden1 & src1_pend) | (head.rden2 & src2_pend) | (head.wren & dst_pend);
    assign head_present = ~empty | bypass;
    assign out_valid    = head_present & ~hazard_head & ~flush;
    assign hazard       = ~empty & hazard_head;

    assign deq   = out_valid & out_ready;
    assign enq   = in_valid & in_ready & ~flush;
    // An entry that bypasses straight to execute never occupies storage.
    assign store = enq & ~(empty & deq);
    assign pop   = deq & ~empty;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({store, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale slots are unreachable because count gates the head.
    always_ff @(posedge clock) begin
        if (store)
            mem[wr_ptr] <= in_entry;
    end

    assign out_pc     = head.pc;
    assign out_instr  = head.instr;
    assign out_waddr  = head.waddr;
    assign out_raddr1 = head.raddr1;
    assign out_raddr2 = head.raddr2;
    assign out_wren   = head.wren;
    assign out_rden1  = head.rden1;
    assign out_rden2  = head.rden2;
    assign out_long   = head.long_op;

endmodule

// File: tb/tb_decode_queue.sv
// Directed scoreboard bench for decode_queue in its default build (no bypass).
module tb_decode_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready, wb_valid;
    logic [31:0] in_pc, in_instr;
    logic [4:0]  in_waddr, in_raddr1, in_raddr2, wb_waddr;
    logic        in_wren, in_rden1, in_rden2, in_long;
    logic        in_ready, out_valid, hazard;
    logic [31:0] out_pc, out_instr;
    logic [4:0]  out_waddr, out_raddr1, out_raddr2;
    logic        out_wren, out_rden1, out_rden2, out_long;
    logic [2:0]  count;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          exp_count = 0;
    logic [31:0] exp_q [$];

    always #5 clock = ~clock;

    decode_queue #(.DEPTH(DEPTH), .XLEN(32), .NREGS(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .in_waddr(in_waddr), .in_raddr1(in_raddr1), .in_raddr2(in_raddr2),
        .in_wren(in_wren), .in_rden1(in_rden1), .in_rden2(in_rden2), .in_long(in_long),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_waddr(out_waddr), .out_raddr1(out_raddr1), .out_raddr2(out_raddr2),
        .out_wren(out_wren), .out_rden1(out_rden1), .out_rden2(out_rden2), .out_long(out_long),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr), .count(count), .hazard(hazard)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0033} ^ 32'hA500_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] wa, input logic we,
                         input logic [4:0] r1, input logic re1, input logic [4:0] r2,
                         input logic re2, input logic lng);
        in_valid = 1'b1; in_pc = pc; in_instr = instr_of(pc);
        in_waddr = wa; in_wren = we; in_raddr1 = r1; in_rden1 = re1;
        in_raddr2 = r2; in_rden2 = re2; in_long = lng;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_pc = '0; in_instr = '0; in_waddr = '0; in_wren = 1'b0;
        in_raddr1 = '0; in_rden1 = 1'b0; in_raddr2 = '0; in_rden2 = 1'b0; in_long = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic v, input logic h);
        #1;
        check({tag, "_out_valid"}, out_valid, v);
        check({tag, "_hazard"}, hazard, h);
    endtask

    // Checks handshakes against the model for this cycle, updates the model, advances one clock.
    task automatic tick();
        logic [31:0] exp_pc;
        logic        accept;
        #1;
        if (reset) begin
            exp_q.delete();
            exp_count = 0;
        end else begin
            check("in_ready", in_ready, exp_count < DEPTH);
            check("count", count, exp_count);
            accept = in_valid && (exp_count < DEPTH) && !flush;
            if (flush)
                check("flush_out_valid", out_valid, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("issue_with_empty_model", 1'b0, 1'b1);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("out_pc", out_pc, exp_pc);
                    check("out_instr", out_instr, instr_of(exp_pc));
                    exp_count--;
                end
            end
            if (flush) begin
                exp_q.delete();
                exp_count = 0;
            end else if (accept) begin
                exp_q.push_back(in_pc);
                exp_count++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; wb_waddr = '0;
        idle_in();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_count", count, 3'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_hazard", hazard, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_flags", {out_wren, out_rden1, out_rden2, out_long}, 4'h0);

        // Fill with execute stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin
            offer(32'(i * 4), 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        offer(32'h10, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("full_count", count, 3'd4);
        check("full_in_ready", in_ready, 1'b0);
        tick();
        idle_in();
        #1;
        check("full_count_after_5th", count, 3'd4);
        out_ready = 1'b1;
        repeat (4) tick();
        #1;
        check("drain_count", count, 3'd0);
        check("drain_out_valid", out_valid, 1'b0);

        // Steady-state enqueue/dequeue pairs wrap both pointers.
        offer(32'h100, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            offer(32'h104 + 32'(4 * i), 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            #1;
            check("wrap_head_valid", out_valid, 1'b1);
            tick();
        end
        idle_in();
        tick();
        #1;
        check("wrap_count", count, 3'd0);

        // Long op writing x5, then a dependent reader stalls until writeback.
        offer(32'h200, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        offer(32'h204, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_head("latency", 1'b1, 1'b0);
        tick();
        idle_in();
        expect_head("raw_blocked", 1'b0, 1'b1);
        tick();
        wb_valid = 1'b1; wb_waddr = 5'd5;
        expect_head("raw_wb_cycle", 1'b0, 1'b1);
        tick();
        wb_valid = 1'b0; wb_waddr = '0;
        expect_head("raw_unblocked", 1'b1, 1'b0);
        tick();

        // Register 0 is never tracked.
        offer(32'h210, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        offer(32'h214, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        idle_in();
        expect_head("x0_no_hazard", 1'b1, 1'b0);
        tick();

        // Set and clear of x7 in the same cycle: set wins.
        offer(32'h300, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        wb_valid = 1'b1; wb_waddr = 5'd7;
        offer(32'h304, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        wb_valid = 1'b0; wb_waddr = '0;
        idle_in();
        expect_head("collision_set_wins", 1'b0, 1'b1);
        wb_valid = 1'b1; wb_waddr = 5'd7;
        tick();
        wb_valid = 1'b0; wb_waddr = '0;
        expect_head("collision_cleared", 1'b1, 1'b0);
        tick();

        // Flush with three queued entries and an incoming offer; x5 stays pending.
        offer(32'h400, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        idle_in();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h404 + 32'(4 * i), 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        offer(32'h410, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush_cycle_out_valid", out_valid, 1'b0);
        check("flush_cycle_count", count, 3'd3);
        tick();
        flush = 1'b0;
        idle_in();
        #1;
        check("post_flush_count", count, 3'd0);
        check("post_flush_out_valid", out_valid, 1'b0);
        offer(32'h420, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        offer(32'h424, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        offer(32'h428, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        idle_in();
        expect_head("flush_pend_kept", 1'b0, 1'b1);
        check("pre_reset_count", count, 3'd3);

        // Reset mid-stream abandons the queue and clears the scoreboard.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midrst_count", count, 3'd0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_hazard", hazard, 1'b0);
        offer(32'h500, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        idle_in();
        expect_head("midrst_pend_clear", 1'b1, 1'b0);
        tick();
        #1;
        check("model_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised instruction buffer between fetch/decode and execute. Holds up to DEPTH instruction entries in FIFO order and issues them under a valid/ready handshake. Tracks pending destination registers of long-latency operations (division, multi-cycle bit-manipulation, CSR writes) in a per-register scoreboard. The per-register stalls replace the global "stall while a long op is in execute" rule: only dependent instructions wait.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- XLEN, 32, width of pc
- NREGS, 32, architectural registers tracked by the scoreboard; register 0 is never tracked
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all queued entries (jump, exception, mret, trap)
- in_valid  in  1  entry offered by decode
- in_ready  out  1  queue accepts an entry
- in_pc  in  XLEN  entry pc
- in_instr  in  32  raw instruction
- in_waddr, in_raddr1, in_raddr2  in  $clog2(NREGS) each  register addresses
- in_wren, in_rden1, in_rden2  in  1 each  register enables
- in_long  in  1  entry is a long-latency op whose writeback is signalled separately
- out_valid  out  1  head entry may issue
- out_ready  in  1  execute accepts the head
- out_pc, out_instr, out_waddr, out_raddr1, out_raddr2, out_wren, out_rden1, out_rden2, out_long  out  same widths  head entry fields
- wb_valid  in  1  a long op completed writeback
- wb_waddr  in  $clog2(NREGS)  register written by the completing long op
- count  out  $clog2(DEPTH)+1  occupied entries
- hazard  out  1  a head entry is present but blocked by the scoreboard

## Operation
- **Storage.** Circular buffer of DEPTH entries with read and write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- **Full/empty.** Determined from count, not from pointer equality.
- **Enqueue.** Occurs on in_valid & in_ready & !flush.
- **in_ready.** in_ready = (count < DEPTH). No same-cycle pass-through when full.
- **Dequeue.** Occurs on out_valid & out_ready.
- **Scoreboard.** pend[NREGS-1:1] register.
  - Set pend[out_waddr] on dequeue when out_long & out_wren & out_waddr != 0.
  - Clear pend[wb_waddr] on wb_valid & wb_waddr != 0.
  - If set and clear target the same register in the same cycle, set wins.
- **Hazard check** on the head entry, using registered pend:
  - (out_rden1 & pend[out_raddr1]) | (out_rden2 & pend[out_raddr2]) | (out_wren & pend[out_waddr])
  - Address 0 never hazards.
- **Issue.** out_valid = !empty & !hazard_head & !flush. hazard = !empty & hazard_head.
- **Flush.**
  - Next-cycle count = 0 and both pointers are reset to 0.
  - A same-cycle enqueue is dropped.
  - A same-cycle dequeue does not occur, because out_valid is forced to 0.
  - pend is not cleared: long ops already issued still write back.
- **Count update.** Enqueue without dequeue: +1. Dequeue without enqueue: -1. Both in the same cycle: unchanged.

## Timing
- **Reset values.** count 0, out_valid 0, in_ready 1, hazard 0, pend all 0, pointers 0, out_* fields 0.
- **Latency.** An entry enqueued in cycle N is visible at the head with out_valid=1 in cycle N+1, when empty and hazard-free.
- **Writeback to issue.** A wb_valid clearing a pending register in cycle N unblocks the head in cycle N+1.
- **Head-of-line blocking.** A blocked head blocks all younger entries; issue is strictly in order.
- **Reset mid-operation.** Queue contents are abandoned; the next cycle matches the reset values.

## Configuration
- **DECODE_QUEUE_BYPASS_EN defined.**
  - When count = 0, in_valid=1, flush=0 and the incoming entry has no hazard against pend, out_valid=1 in the same cycle.
  - out_* fields then mirror in_* combinationally.
  - If out_ready=1, the entry issues and is not written into storage; if out_ready=0, it is enqueued normally.
- **Macro undefined.** Minimum latency is 1 cycle, as given under Timing.

## Structure
- **Shared package.** decode_queue_entry_type (packed struct of all in_*/out_* fields) and init_decode_queue_entry.
- **Sub-module decode_scoreboard.**
  - Holds pend.
  - Ports: set_en, set_addr, clr_en, clr_addr, two read ports for the source registers, one read port for the destination register, three hazard bits.
- The FIFO logic lives in decode_queue.

## Test plan
- **Fill/drain.** Enqueue 4 entries with pc 0x0,0x4,0x8,0xC and out_ready=0. Expect count=4 and in_ready=0; a 5th offer is not accepted. Then out_ready=1: pcs issue in order over 4 cycles and count returns to 0.
- **Wrap-around.** Run 10 enqueue/dequeue pairs in steady state. Expect the out_pc sequence to equal the input sequence and count to stay at 1.
- **RAW on long op.**
  - Issue a long op writing x5, then an entry reading x5 with rden1=1. Expect hazard=1 and out_valid=0.
  - Assert wb_valid with wb_waddr=5. Expect out_valid=1 the next cycle.
  - An entry writing x0 never blocks.
- **Set/clear collision.** A dequeue of a long op writing x7 coincides with wb_valid, wb_waddr=7. Expect pend[7]=1 afterwards.
- **Flush.** With 3 entries queued and in_valid=1, pulse flush. Expect out_valid=0 that cycle, count=0 next, and the incoming entry dropped. pend is unchanged: x5 is still pending.
- **Reset mid-stream.** Assert reset with count=3 and pend[5]=1. Next cycle: count=0, pend all 0, out_valid=0, in_ready=1.
